vga_cfg_regbank: RTL

- Downstream consumer of address_decoder.
- Accepts {address, data} write requests over a valid/ack handshake and stores them in a 16 x 4-bit shadow register bank.
- Copies the shadow bank into the active registers that drive the VGA pixel stage. The copy happens only at a frame boundary, and only after an explicit commit command, so the picture never tears mid-frame.

---
 rtl/vga_cfg_regbank.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vga_cfg_regbank.sv
// ---------------------------------------------------------------------------
// vga_cfg_regbank
//
// Purpose:
//   Shadow/active configuration register bank for the VGA pixel stage.
//   Writes from address_decoder land in a 16 x 4-bit shadow bank over a
//   valid/ack handshake. A write to COMMIT_ADDR arms a commit. The active
//   registers are refreshed from the shadow bank only on the next
//   frame_start, so the picture never changes mid-frame.
//
// Optional feature (compile-time macro CFG_WRITE_LOCK_EN):
//   Address 4'hD becomes a lock register (data[0]=1 locks). While locked,
//   writes to 0..12 and COMMIT_ADDR are dropped but still acked, and
//   lock_violation pulses together with ack. Without the macro, 4'hD is an
//   ordinary general register and lock_violation is constant 0.
//
// Ports:
//   clk            in   system clock (shared with address_decoder)
//   rst            in   synchronous active-high reset
//   valid          in   write request, held until ack is seen
//   address[3:0]   in   register index
//   data[3:0]      in   register write data
//   frame_start    in   one-cycle pulse at start of vertical blanking
//   ack            out  one-cycle write acknowledge
//   mode[3:0]      out  active reg 0
//   fg_rgb[11:0]   out  active {reg1, reg2, reg3}
//   bg_rgb[11:0]   out  active {reg4, reg5, reg6}
//   pattern[3:0]   out  active reg 7
//   commit_pending out  commit armed, waiting for frame_start
//   commit_done    out  one-cycle pulse when the active bank was updated
//   lock_violation out  one-cycle pulse on a write dropped by the lock
//
// Handshake FSM:
//   state    | meaning
//   IDLE     | waiting for valid; write performed on the accepting edge
//   ACK      | ack high for this single cycle
//   WAIT_LOW | request served, waiting for valid to drop
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_cfg_regbank #(
    parameter logic [3:0]  COMMIT_ADDR = 4'hF,
    parameter logic [11:0] RESET_FG    = 12'hFFF,
    parameter logic [11:0] RESET_BG    = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [3:0]  address,
    input  logic [3:0]  data,
    input  logic        frame_start,
    output logic        ack,
    output logic [3:0]  mode,
    output logic [11:0] fg_rgb,
    output logic [11:0] bg_rgb,
    output logic [3:0]  pattern,
    output logic        commit_pending,
    output logic        commit_done,
    output logic        lock_violation
);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW
    } state_t;

    state_t     state;
    logic [3:0] shadow [0:15];
    logic       write_blocked;

`ifdef CFG_WRITE_LOCK_EN
    localparam logic [3:0] LOCK_ADDR = 4'hD;

    logic locked;

    // The lock register itself stays writable so a locked bank can be freed.
    assign write_blocked = locked && (address != LOCK_ADDR) &&
                           ((address <= 4'd12) || (address == COMMIT_ADDR));
`else
    assign write_blocked  = 1'b0;
    assign lock_violation = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ack            <= 1'b0;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= 4'h0;
            end
            shadow[1]      <= RESET_FG[11:8];
            shadow[2]      <= RESET_FG[7:4];
            shadow[3]      <= RESET_FG[3:0];
            shadow[4]      <= RESET_BG[11:8];
            shadow[5]      <= RESET_BG[7:4];
            shadow[6]      <= RESET_BG[3:0];
            mode           <= 4'h0;
            fg_rgb         <= RESET_FG;
            bg_rgb         <= RESET_BG;
            pattern        <= 4'h0;
`ifdef CFG_WRITE_LOCK_EN
            locked         <= 1'b0;
            lock_violation <= 1'b0;
`endif
        end else begin
            ack         <= 1'b0;
            commit_done <= 1'b0;
`ifdef CFG_WRITE_LOCK_EN
            lock_violation <= 1'b0;
`endif

            // The copy reads the pre-edge shadow values, so a write landing
            // on the same edge waits for the next commit. The pending flag
            // tested here is also the pre-edge one: a commit write on this
            // edge only arms the following frame.
            if (frame_start && commit_pending) begin
                mode           <= shadow[0];
                fg_rgb         <= {shadow[1], shadow[2], shadow[3]};
                bg_rgb         <= {shadow[4], shadow[5], shadow[6]};
                pattern        <= shadow[7];
                commit_pending <= 1'b0;
                commit_done    <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (valid) begin
                        ack   <= 1'b1;
                        state <= ACK;
`ifdef CFG_WRITE_LOCK_EN
                        lock_violation <= write_blocked;
`endif
                        if (!write_blocked) begin
                            // Placed after the copy so a re-armed commit
                            // overrides the clear of the frame just served.
                            if (address == COMMIT_ADDR) begin
                                commit_pending <= 1'b1;
`ifdef CFG_WRITE_LOCK_EN
                            end else if (address == LOCK_ADDR) begin
                                locked <= data[0];
`endif
                            end else begin
                                shadow[address] <= data;
                            end
                        end
                    end
                end
                ACK: begin
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
